// File: rtl/csi2_long_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csi2_long_pkt_ctrl
// Brief    : CSI-2 packet sequencer. It decodes each header, turns short packets
//            into sync pulses, and forwards only the payload of matching long
//            packets, with tlast on the final payload word.
// Revision : 1.0 - initial release
// ============================================================================
module csi2_long_pkt_ctrl #(
  parameter logic [5:0] DATA_TYPE = 6'h2B,
  parameter logic [1:0] VIRT_CHAN = 2'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] pkt_i_tdata,
  input  logic        pkt_i_tvalid,
  input  logic        pkt_i_tlast,
  output logic        pkt_i_tready,
  output logic [31:0] pkt_o_tdata,
  output logic [3:0]  pkt_o_tkeep,
  output logic        pkt_o_tvalid,
  output logic        pkt_o_tlast,
  input  logic        pkt_o_tready,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic [15:0] frame_num_o,
  output logic        frame_active_o,
  output logic        trunc_err_o
);

  localparam logic [5:0] c_dt_fs = 6'h00;
  localparam logic [5:0] c_dt_fe = 6'h01;
  localparam logic [5:0] c_dt_ls = 6'h02;
  localparam logic [5:0] c_dt_le = 6'h03;

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_bytes_left;
  logic [31:0] r_out_data;
  logic [3:0]  r_out_keep;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_fs, r_fe, r_ls, r_le, r_trunc;
  logic [15:0] r_frame_num;
  logic        r_frame_active;

  logic [5:0]  w_dt;
  logic [1:0]  w_vc;
  logic [15:0] w_wc;
  logic        w_short;
  logic        w_vc_hit;
  logic        w_long_hit;
  logic        w_accept;
  logic        w_last_word;
  logic [3:0]  w_keep_last;

  assign w_dt        = pkt_i_tdata[5:0];
  assign w_vc        = pkt_i_tdata[7:6];
  assign w_wc        = pkt_i_tdata[23:8];
  assign w_short     = (w_dt < 6'h10);
  assign w_vc_hit    = (w_vc == VIRT_CHAN);
  assign w_long_hit  = !w_short && w_vc_hit && (w_dt == DATA_TYPE) && (w_wc != 16'd0);
  assign w_last_word = (r_bytes_left <= 16'd4);

  // Only the payload phase may stall the lane merger.
  assign pkt_i_tready = (r_state != S_PAYLOAD) || !r_out_valid || pkt_o_tready;
  assign w_accept     = pkt_i_tvalid && pkt_i_tready;

  always_comb begin
    w_keep_last = 4'hF;
    case (r_bytes_left[2:0])
      3'd1:    w_keep_last = 4'b0001;
      3'd2:    w_keep_last = 4'b0011;
      3'd3:    w_keep_last = 4'b0111;
      default: w_keep_last = 4'b1111;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_HDR;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: begin
        if (w_accept && !pkt_i_tlast)
          w_state_nxt = w_long_hit ? S_PAYLOAD : S_DISCARD;
      end
      S_PAYLOAD: begin
        if (w_accept) begin
          if (pkt_i_tlast)      w_state_nxt = S_HDR;
          else if (w_last_word) w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (w_accept && pkt_i_tlast) w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bytes_left   <= 16'd0;
      r_out_data     <= 32'd0;
      r_out_keep     <= 4'd0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_fs           <= 1'b0;
      r_fe           <= 1'b0;
      r_ls           <= 1'b0;
      r_le           <= 1'b0;
      r_trunc        <= 1'b0;
      r_frame_num    <= 16'd0;
      r_frame_active <= 1'b0;
    end else begin
      r_fs    <= 1'b0;
      r_fe    <= 1'b0;
      r_ls    <= 1'b0;
      r_le    <= 1'b0;
      r_trunc <= 1'b0;
      if (pkt_o_tready) r_out_valid <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_HDR: begin
            if (w_short && w_vc_hit) begin
              case (w_dt)
                c_dt_fs: begin
                  r_fs           <= 1'b1;
                  r_frame_num    <= w_wc;
                  r_frame_active <= 1'b1;
                end
                c_dt_fe: begin
                  r_fe           <= 1'b1;
                  r_frame_active <= 1'b0;
                end
                c_dt_ls: r_ls <= 1'b1;
                c_dt_le: r_le <= 1'b1;
                default: ;
              endcase
            end else if (w_long_hit) begin
              r_bytes_left <= w_wc;
              // A long header that is also the physical end has lost its payload.
              r_trunc      <= pkt_i_tlast;
            end
          end
          S_PAYLOAD: begin
            r_out_data   <= pkt_i_tdata;
            r_out_valid  <= 1'b1;
            r_bytes_left <= w_last_word ? 16'd0 : (r_bytes_left - 16'd4);
            if (w_last_word) begin
              r_out_last <= 1'b1;
              r_out_keep <= w_keep_last;
            end else if (pkt_i_tlast) begin
              r_out_last <= 1'b1;
              r_out_keep <= 4'hF;
              r_trunc    <= 1'b1;
            end else begin
              r_out_last <= 1'b0;
              r_out_keep <= 4'hF;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pkt_o_tdata    = r_out_data;
  assign pkt_o_tkeep    = r_out_keep;
  assign pkt_o_tvalid   = r_out_valid;
  assign pkt_o_tlast    = r_out_last;
  assign frame_start_o  = r_fs;
  assign frame_end_o    = r_fe;
  assign line_start_o   = r_ls;
  assign line_end_o     = r_le;
  assign frame_num_o    = r_frame_num;
  assign frame_active_o = r_frame_active;
  assign trunc_err_o    = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_csi2_long_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi2_long_pkt_ctrl
// Brief    : Directed bench for csi2_long_pkt_ctrl with an output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi2_long_pkt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] pkt_o_tdata;
  logic [3:0]  pkt_o_tkeep;
  logic        pkt_o_tvalid, pkt_o_tlast, pkt_o_tready;
  logic        frame_start_o, frame_end_o, line_start_o, line_end_o;
  logic [15:0] frame_num_o;
  logic        frame_active_o, trunc_err_o;

  always #5 clk = ~clk;

  csi2_long_pkt_ctrl dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .pkt_i_tdata    (in_data),
    .pkt_i_tvalid   (in_valid),
    .pkt_i_tlast    (in_last),
    .pkt_i_tready   (in_ready),
    .pkt_o_tdata    (pkt_o_tdata),
    .pkt_o_tkeep    (pkt_o_tkeep),
    .pkt_o_tvalid   (pkt_o_tvalid),
    .pkt_o_tlast    (pkt_o_tlast),
    .pkt_o_tready   (pkt_o_tready),
    .frame_start_o  (frame_start_o),
    .frame_end_o    (frame_end_o),
    .line_start_o   (line_start_o),
    .line_end_o     (line_end_o),
    .frame_num_o    (frame_num_o),
    .frame_active_o (frame_active_o),
    .trunc_err_o    (trunc_err_o)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    ready_mode = 0;
  int    fs_cnt = 0, fe_cnt = 0, ls_cnt = 0, le_cnt = 0, trunc_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sink readiness: 0 = always ready, 1 = random, 2 = never ready.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       pkt_o_tready = 1'b1;
      1:       pkt_o_tready = 1'($urandom_range(0, 1));
      default: pkt_o_tready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    fs_cnt    += int'(frame_start_o);
    fe_cnt    += int'(frame_end_o);
    ls_cnt    += int'(line_start_o);
    le_cnt    += int'(line_end_o);
    trunc_cnt += int'(trunc_err_o);
    if (rst_n && pkt_o_tvalid && pkt_o_tready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_out: observed data=%h expected no beat", pkt_o_tdata);
      end
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_data", pkt_o_tdata, e.d);
        chk("out_keep", pkt_o_tkeep, e.k);
        chk("out_last", pkt_o_tlast, e.l);
      end
    end
  end

  // Drives one input beat and returns at posedge+1 after it is accepted.
  task automatic beat(input logic [31:0] d, input logic l, output int stalls);
    bit acc = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    stalls   = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        break;
      end
      stalls++;
    end
    total++;
    assert (acc) else begin
      bad++;
      $error("FAIL accept_timeout: observed stalls=%0d expected accept", stalls);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pay(input logic [31:0] d, input logic l, input logic [3:0] k, input logic el);
    int st;
    beat_t e;
    e.d = d; e.k = k; e.l = el;
    exp_q.push_back(e);
    beat(d, l, st);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, sum;
    rst_n        = 1'b0;
    in_data      = 32'd0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    pkt_o_tready = 1'b1;

    // Reset with random traffic on the input
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      in_data  = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_outs", {pkt_o_tvalid, pkt_o_tlast, pkt_o_tdata, pkt_o_tkeep, frame_start_o,
                       frame_end_o, line_start_o, line_end_o, frame_num_o, frame_active_o,
                       trunc_err_o}, 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(2);

    // Short packets on VC0
    beat(32'h0000_0700, 1'b1, st);
    chk("fs_pulse", frame_start_o, 1);
    chk("frame_num", frame_num_o, 16'd7);
    chk("active_after_fs", frame_active_o, 1);
    idle(1);
    chk("fs_one_cycle", frame_start_o, 0);
    beat(32'h0000_0002, 1'b1, st);
    chk("ls_pulse", line_start_o, 1);
    beat(32'h0000_0003, 1'b1, st);
    chk("le_pulse", line_end_o, 1);
    chk("ls_one_cycle", line_start_o, 0);
    chk("active_mid", frame_active_o, 1);
    beat(32'h0000_0001, 1'b1, st);
    chk("fe_pulse", frame_end_o, 1);
    chk("active_after_fe", frame_active_o, 0);
    idle(1);
    chk("pulse_counts", {fs_cnt[7:0], fe_cnt[7:0], ls_cnt[7:0], le_cnt[7:0]}, 32'h01010101);

    // Same sequence on VC1 is ignored
    beat(32'h0000_0940, 1'b1, st);
    beat(32'h0000_0042, 1'b1, st);
    beat(32'h0000_0043, 1'b1, st);
    beat(32'h0000_0041, 1'b1, st);
    idle(2);
    chk("vc1_no_pulses", {fs_cnt[7:0], fe_cnt[7:0], ls_cnt[7:0], le_cnt[7:0]}, 32'h01010101);
    chk("vc1_frame_num", frame_num_o, 16'd7);

    // RAW10 WC=10, then WC=8 header back-to-back
    beat(32'h0000_0A2B, 1'b0, st);
    pay(32'hA000_0001, 1'b0, 4'hF, 1'b0);
    pay(32'hA000_0002, 1'b0, 4'hF, 1'b0);
    pay(32'hA000_0003, 1'b1, 4'b0011, 1'b1);
    beat(32'h0000_082B, 1'b0, st);
    chk("no_gap_hdr", st, 0);
    pay(32'hB000_0001, 1'b0, 4'hF, 1'b0);
    pay(32'hB000_0002, 1'b0, 4'hF, 1'b1);
    beat(32'hCC0C_C0CC, 1'b1, st);
    wait_drain();

    // Random sink backpressure
    ready_mode = 1;
    for (int r = 0; r < 3; r++) begin
      beat(32'h0000_082B, 1'b0, st);
      pay(32'hC000_0000 + r, 1'b0, 4'hF, 1'b0);
      pay(32'hC100_0000 + r, 1'b0, 4'hF, 1'b1);
      beat(32'hDEAD_BEEF, 1'b1, st);
      beat(32'h0000_0A2B, 1'b0, st);
      pay(32'hC200_0000 + r, 1'b0, 4'hF, 1'b0);
      pay(32'hC300_0000 + r, 1'b0, 4'hF, 1'b0);
      pay(32'hC400_0000 + r, 1'b1, 4'b0011, 1'b1);
    end
    wait_drain();
    ready_mode = 0;
    idle(1);

    // Non-matching data type is dropped without stalling
    beat(32'h0000_282A, 1'b0, sum);
    for (int i = 0; i < 11; i++) begin
      beat(32'hE000_0000 + i, (i == 10), st);
      sum += st;
    end
    chk("filter_no_stall", sum, 0);
    beat(32'h0000_0A2B, 1'b0, st);
    pay(32'hD000_0001, 1'b0, 4'hF, 1'b0);
    pay(32'hD000_0002, 1'b0, 4'hF, 1'b0);
    pay(32'hD000_0003, 1'b1, 4'b0011, 1'b1);
    wait_drain();

    // Truncated payload
    beat(32'h0000_142B, 1'b0, st);
    pay(32'hF000_0001, 1'b0, 4'hF, 1'b0);
    pay(32'hF000_0002, 1'b1, 4'hF, 1'b1);
    chk("trunc_pulse", trunc_err_o, 1);
    idle(1);
    chk("trunc_one_cycle", trunc_err_o, 0);
    beat(32'h0000_0002, 1'b1, st);
    chk("resume_ls", line_start_o, 1);
    beat(32'h0000_0A2B, 1'b1, st);
    chk("hdr_trunc_pulse", trunc_err_o, 1);
    beat(32'h0000_0003, 1'b1, st);
    chk("hdr_trunc_stays_hdr", line_end_o, 1);
    wait_drain();
    chk("trunc_count", trunc_cnt, 2);

    // Asynchronous reset in the middle of a payload
    ready_mode = 2;
    idle(1);
    beat(32'h0000_282B, 1'b0, st);
    beat(32'h9000_0001, 1'b0, st);
    chk("held_valid", pkt_o_tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", pkt_o_tvalid, 0);
    chk("rst_async_data", pkt_o_tdata, 0);
    @(posedge clk); #1;
    rst_n      = 1'b1;
    ready_mode = 0;
    idle(1);
    beat(32'h0000_0300, 1'b1, st);
    chk("post_rst_fs", frame_start_o, 1);
    chk("post_rst_frame_num", frame_num_o, 16'd3);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csi2_long_pkt_ctrl.md
# csi2_long_pkt_ctrl

Packet sequencer placed between the CSI-2 lane merger and the RAW10 32b→40b gearbox. Decodes each 32-bit packet header, turns short packets into frame/line sync pulses, forwards only the payload of matching long packets with `tlast` on the final payload word, and discards headers, CRC footers and non-matching packets. The gearbox sees clean per-line payload streams framed by `tlast`.

## Interface
- `DATA_TYPE`, 6'h2B: long-packet data type forwarded (RAW10); other long packets dropped.
- `VIRT_CHAN`, 2'd0: virtual channel accepted; all other VCs, short or long, are ignored.
- `clk_i`  in  1  single clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `pkt_i`  axi4_stream_if.slave  32b tdata  merged lane words; `tlast` marks the end of a physical packet. Byte 0 is `tdata[7:0]`.
- `pkt_o`  axi4_stream_if.master  32b tdata + 4b tkeep  payload words to the gearbox.
- `frame_start_o`, `frame_end_o`, `line_start_o`, `line_end_o`  out  1  one-cycle sync pulses.
- `frame_num_o`  out  16  frame number captured from the FS short packet.
- `frame_active_o`  out  1  high from FS to FE.
- `trunc_err_o`  out  1  one-cycle pulse: packet ended before its payload completed.

## Operation
- Header word: `[5:0]` DT, `[7:6]` VC, `[23:8]` WC (bytes for long, data field for short), `[31:24]` ECC (not checked). Short packet iff DT < 6'h10.
- States: HDR, PAYLOAD, DISCARD.
- HDR (`pkt_i.tready`=1): on accepted beat:
  - short, VC match: DT 0x00 → `frame_start_o`, `frame_num_o`←WC, `frame_active_o`←1; 0x01 → `frame_end_o`, `frame_active_o`←0; 0x02 → `line_start_o`; 0x03 → `line_end_o`; others no effect. Stay in HDR if `tlast`=1, else → DISCARD.
  - long, VC and DT match, WC≠0: `bytes_left`←WC, → PAYLOAD (if `tlast`=1 on header, pulse `trunc_err_o`, stay HDR).
  - anything else: → DISCARD unless `tlast`=1.
- PAYLOAD: `pkt_i.tready = !pkt_o.tvalid || pkt_o.tready`. Each accepted beat loads `pkt_o.tdata`←`pkt_i.tdata`, `pkt_o.tvalid`←1, `bytes_left`←`bytes_left`−4 (16-bit, no wrap: saturates at 0).
  - `bytes_left` ≤ 4: `pkt_o.tlast`←1, `tkeep` ← 4'b0001/0011/0111/1111 for 1/2/3/4; CRC bytes are discarded. Next state HDR if `pkt_i.tlast`, else DISCARD.
  - `bytes_left` > 4 and `pkt_i.tlast`=1: `pkt_o.tlast`←1, `tkeep`←4'hF, `trunc_err_o` pulse, → HDR.
  - otherwise `tlast`←0, `tkeep`←4'hF.
- DISCARD: `pkt_i.tready`=1; drop beats; on `tlast` → HDR.
- `pkt_o.tvalid` clears when `pkt_o.tready`=1 and no new beat loads in the same cycle; `tdata/tkeep/tlast` hold while `tvalid && !tready`.

## Timing
- Reset (`rst_n_i`=0, any time, mid-packet included): state HDR, `pkt_o.tvalid/tlast`=0, `tdata`=0, `tkeep`=0, all pulses 0, `frame_num_o`=0, `frame_active_o`=0, `bytes_left`=0. First word after release is treated as a header.
- Payload latency: 1 cycle from input accept to `pkt_o.tvalid`. Sustained 1 word/cycle with `pkt_o.tready`=1; no bubble between HDR and first payload beat on input.
- Sync pulses and `trunc_err_o` assert the cycle after the accepting edge, exactly one cycle.
- Backpressure only in PAYLOAD; HDR/DISCARD never stall input.
- FS while `frame_active_o`=1: new FS pulse, `frame_num_o` updated, stays active. FE without FS: pulse, active stays 0.

## Test plan
- Reset & idle: hold `rst_n_i`=0 with random `pkt_i` traffic → all outputs 0; release → first word decoded as header.
- Short packets: FS WC=16'h0007, LS, LE, FE on VC0 → one pulse each, `frame_num_o`=7, `frame_active_o` high from FS+1 to FE+1; same on VC1 → no pulses.
- RAW10 line WC=10: header + 3 payload words (last holds 2 data + 2 CRC bytes, `tlast`) → 3 output words, third `tkeep`=4'b0011, `tlast`=1; next header decoded with no gap.
- WC=8: header + 2 payload + 1 CRC word → 2 outputs, second `tkeep`=4'hF `tlast`=1, CRC word dropped; random `pkt_o.tready` → identical data, no loss/duplication.
- Filter: long packet DT=6'h2A, WC=40 → no output, input never stalled, following RAW10 packet forwarded intact.
- Truncation: WC=20 but `pkt_i.tlast` on 2nd payload word → 2 outputs, second `tlast`=1 `tkeep`=4'hF, one `trunc_err_o` pulse, then header decoding resumes; assert `rst_n_i` mid-PAYLOAD → `pkt_o.tvalid` drops immediately.
